// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the shared 32-word data memory.
// Each accepted command takes three cycles: grant (IDLE), memory access (ACCESS), response (RESP).
module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MEM_WORDS = 32,
  parameter bit RR_EN     = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          we_a,
  input  logic          byte_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic          byte_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          done_a,
  output logic          done_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          err_a,
  output logic          err_b,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we_n,
  output logic          mem_word,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_WORDS);

  state_t        state_r;
  state_t        state_s;
  logic          last_b_r;
  logic          pick_b_s;
  logic          grant_s;
  logic          sel_we_s;
  logic          sel_byte_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;
  logic          cmd_b_r;
  logic          cmd_we_r;
  logic          cmd_byte_r;
  logic          cmd_range_r;
  logic [DW-1:0] result_s;
  logic          gnt_a_s;
  logic          gnt_b_s;
  logic          done_a_r;
  logic          done_b_r;
  logic          err_a_r;
  logic          err_b_r;
  logic [DW-1:0] rdata_a_r;
  logic [DW-1:0] rdata_b_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  logic          mem_we_n_r;
  logic          mem_word_r;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return (addr < MEM_LIMIT);
  endfunction

  // Byte reads return only bits 7:0, zero-extended.
  function automatic logic [DW-1:0] read_extend(input logic is_byte, input logic [DW-1:0] data);
    if (is_byte) begin
      return {{(DW-8){1'b0}}, data[7:0]};
    end else begin
      return data;
    end
  endfunction

  // Winner selection: a lone requester always wins; a tie goes to whoever was not served last.
  always_comb begin
    pick_b_s = 1'b0;
    if (req_a && req_b) begin
      if (RR_EN) begin
        pick_b_s = ~last_b_r;
      end else begin
        pick_b_s = 1'b0;
      end
    end else if (req_b) begin
      pick_b_s = 1'b1;
    end else begin
      pick_b_s = 1'b0;
    end
  end

  // Grant is only possible in IDLE; requests while busy are ignored.
  always_comb begin
    grant_s = (state_r == IDLE) && (req_a || req_b);
    gnt_a_s = grant_s && !pick_b_s;
    gnt_b_s = grant_s && pick_b_s;
  end

  // Mux the winning command.
  always_comb begin
    if (pick_b_s) begin
      sel_we_s    = we_b;
      sel_byte_s  = byte_b;
      sel_addr_s  = addr_b;
      sel_wdata_s = wdata_b;
    end else begin
      sel_we_s    = we_a;
      sel_byte_s  = byte_a;
      sel_addr_s  = addr_a;
      sel_wdata_s = wdata_a;
    end
  end

  // Next-state logic for the three-phase access sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS:  state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Value returned to the requester at the end of ACCESS.
  always_comb begin
    result_s = read_extend(cmd_byte_r, mem_rdata);
  end

  // State register and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      last_b_r <= 1'b1;
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        last_b_r <= pick_b_s;
      end
    end
  end

  // Latch the granted command and drive the memory interface during ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_b_r     <= 1'b0;
      cmd_we_r    <= 1'b0;
      cmd_byte_r  <= 1'b0;
      cmd_range_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_we_n_r  <= 1'b1;
      mem_word_r  <= 1'b1;
    end else begin
      mem_we_n_r <= 1'b1;
      if (grant_s) begin
        cmd_b_r     <= pick_b_s;
        cmd_we_r    <= sel_we_s;
        cmd_byte_r  <= sel_byte_s;
        cmd_range_r <= in_range(sel_addr_s);
        mem_addr_r  <= sel_addr_s;
        mem_wdata_r <= sel_wdata_s;
        mem_word_r  <= ~sel_byte_s;
        mem_we_n_r  <= ~(sel_we_s && in_range(sel_addr_s));
      end
    end
  end

  // Completion pulses and read data, registered at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_a_r  <= 1'b0;
      done_b_r  <= 1'b0;
      err_a_r   <= 1'b0;
      err_b_r   <= 1'b0;
      rdata_a_r <= '0;
      rdata_b_r <= '0;
    end else begin
      done_a_r <= 1'b0;
      done_b_r <= 1'b0;
      err_a_r  <= 1'b0;
      err_b_r  <= 1'b0;
      if (state_r == ACCESS) begin
        if (cmd_b_r) begin
          done_b_r <= 1'b1;
          err_b_r  <= ~cmd_range_r;
          if (!cmd_range_r) begin
            rdata_b_r <= '0;
          end else if (!cmd_we_r) begin
            rdata_b_r <= result_s;
          end
        end else begin
          done_a_r <= 1'b1;
          err_a_r  <= ~cmd_range_r;
          if (!cmd_range_r) begin
            rdata_a_r <= '0;
          end else if (!cmd_we_r) begin
            rdata_a_r <= result_s;
          end
        end
      end
    end
  end

  // Output mapping; rst masks the write strobe so an interrupted ACCESS never writes.
  always_comb begin
    gnt_a     = gnt_a_s;
    gnt_b     = gnt_b_s;
    done_a    = done_a_r;
    done_b    = done_b_r;
    err_a     = err_a_r;
    err_b     = err_b_r;
    rdata_a   = rdata_a_r;
    rdata_b   = rdata_b_r;
    busy      = (state_r != IDLE);
    mem_addr  = mem_addr_r;
    mem_wdata = mem_wdata_r;
    mem_we_n  = mem_we_n_r | rst;
    mem_word  = mem_word_r;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written sequences for arbitration, mid-access reset and busy-time requests.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, we_a, byte_a, req_b, we_b, byte_b;
  logic [15:0] addr_a, wdata_a, addr_b, wdata_b;
  logic        gnt_a, gnt_b, done_a, done_b, err_a, err_b, busy;
  logic [15:0] rdata_a, rdata_b, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we_n, mem_word;
  logic        gnt_a0, gnt_b0, done_a0, done_b0, err_a0, err_b0, busy0;
  logic [15:0] rdata_a0, rdata_b0, mem_addr0, mem_wdata0;
  logic        mem_we_n0, mem_word0;
  logic [15:0] mem [0:31];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(16), .DW(16), .MEM_WORDS(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .byte_a(byte_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .byte_b(byte_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .err_a(err_a), .err_b(err_b), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we_n(mem_we_n), .mem_word(mem_word),
    .mem_rdata(mem_rdata)
  );

  // Fixed-priority instance, only its grant pattern is examined.
  mem_arbiter #(.AW(16), .DW(16), .MEM_WORDS(32), .RR_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .byte_a(byte_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .byte_b(byte_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a0), .gnt_b(gnt_b0), .done_a(done_a0), .done_b(done_b0),
    .rdata_a(rdata_a0), .rdata_b(rdata_b0), .err_a(err_a0), .err_b(err_b0), .busy(busy0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we_n(mem_we_n0), .mem_word(mem_word0),
    .mem_rdata(16'h0000)
  );

  // Memory model: async read, write on rising edge, ByteOp 0 writes the low byte only.
  assign mem_rdata = mem[mem_addr[4:0]];
  always @(posedge clk) begin
    if (!mem_we_n) begin
      if (mem_word) mem[mem_addr[4:0]] <= mem_wdata;
      else          mem[mem_addr[4:0]][7:0] <= mem_wdata[7:0];
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_a = 1'b0; we_a = 1'b0; byte_a = 1'b0; addr_a = 16'h0000; wdata_a = 16'h0000;
    req_b = 1'b0; we_b = 1'b0; byte_b = 1'b0; addr_b = 16'h0000; wdata_b = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        sel_b;
    logic        we;
    logic        bt;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_we_n;
    logic        chk_rd;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    rst = 1'b1;
    idle_inputs();
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0004, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h0003, 16'hABCD, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b1, 16'h00CD, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 16'h0000, 1'b1, 1'b1, 16'h0034, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h7777, 1'b1, 1'b1, 16'h0000, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h001F, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h001F, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h001F, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h001F, 16'h0000, 1'b1, 1'b1, 16'h00EF, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, 1'b1, 1'b1, 16'h00CD, 1'b0};

    do_reset();
    #1;
    chk("rst gnt_a", {15'd0, gnt_a}, 16'h0000);
    chk("rst gnt_b", {15'd0, gnt_b}, 16'h0000);
    chk("rst done", {14'd0, done_a, done_b}, 16'h0000);
    chk("rst err", {14'd0, err_a, err_b}, 16'h0000);
    chk("rst rdata_a", rdata_a, 16'h0000);
    chk("rst rdata_b", rdata_b, 16'h0000);
    chk("rst busy", {15'd0, busy}, 16'h0000);
    chk("rst mem_addr", mem_addr, 16'h0000);
    chk("rst mem_wdata", mem_wdata, 16'h0000);
    chk("rst mem_we_n", {15'd0, mem_we_n}, 16'h0001);
    chk("rst mem_word", {15'd0, mem_word}, 16'h0001);

    // Table: one transaction per 3 cycles, checked in every phase.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      idle_inputs();
      if (vecs[i].sel_b) begin
        req_b = 1'b1; we_b = vecs[i].we; byte_b = vecs[i].bt;
        addr_b = vecs[i].addr; wdata_b = vecs[i].wdata;
      end else begin
        req_a = 1'b1; we_a = vecs[i].we; byte_a = vecs[i].bt;
        addr_a = vecs[i].addr; wdata_a = vecs[i].wdata;
      end
      #1;
      chk($sformatf("v%0d gnt_a", i), {15'd0, gnt_a}, {15'd0, ~vecs[i].sel_b});
      chk($sformatf("v%0d gnt_b", i), {15'd0, gnt_b}, {15'd0, vecs[i].sel_b});
      chk($sformatf("v%0d idle we_n", i), {15'd0, mem_we_n}, 16'h0001);
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("v%0d busy", i), {15'd0, busy}, 16'h0001);
      chk($sformatf("v%0d mem_we_n", i), {15'd0, mem_we_n}, {15'd0, vecs[i].exp_we_n});
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("v%0d mem_word", i), {15'd0, mem_word}, {15'd0, ~vecs[i].bt});
      if (!vecs[i].exp_we_n) chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].wdata);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d resp we_n", i), {15'd0, mem_we_n}, 16'h0001);
      chk($sformatf("v%0d done_a", i), {15'd0, done_a}, {15'd0, ~vecs[i].sel_b});
      chk($sformatf("v%0d done_b", i), {15'd0, done_b}, {15'd0, vecs[i].sel_b});
      chk($sformatf("v%0d err", i), {15'd0, vecs[i].sel_b ? err_b : err_a}, {15'd0, vecs[i].exp_err});
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d rdata", i), vecs[i].sel_b ? rdata_b : rdata_a, vecs[i].exp_rdata);
    end

    // Both requesters always asserting: RR alternates A,B; fixed priority grants A only.
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("rr c%0d gnt_a", c), {15'd0, gnt_a}, {15'd0, (c % 6) == 0});
      chk($sformatf("rr c%0d gnt_b", c), {15'd0, gnt_b}, {15'd0, (c % 6) == 3});
      chk($sformatf("fp c%0d gnt_a", c), {15'd0, gnt_a0}, {15'd0, (c % 3) == 0});
      chk($sformatf("fp c%0d gnt_b", c), {15'd0, gnt_b0}, 16'h0000);
      @(negedge clk);
    end

    // Reset during B's write ACCESS: no write, no done, reset values.
    do_reset();
    req_b = 1'b1; we_b = 1'b1; byte_b = 1'b0; addr_b = 16'h0005; wdata_b = 16'h5555;
    #1;
    chk("t5 gnt_b", {15'd0, gnt_b}, 16'h0001);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("t5 we_n under rst", {15'd0, mem_we_n}, 16'h0001);
    @(negedge clk);
    #1;
    chk("t5 busy", {15'd0, busy}, 16'h0000);
    chk("t5 done_b", {15'd0, done_b}, 16'h0000);
    chk("t5 mem_addr", mem_addr, 16'h0000);
    chk("t5 mem_word", {15'd0, mem_word}, 16'h0001);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("t5 done_b late", {15'd0, done_b}, 16'h0000);
    chk("t5 mem[5]", mem[5], 16'h0000);

    // req_b arriving in RESP must wait until the return to IDLE.
    @(negedge clk);
    req_a = 1'b1; addr_a = 16'h0004;
    #1;
    chk("t6 gnt_a", {15'd0, gnt_a}, 16'h0001);
    @(negedge clk);
    req_a = 1'b0;
    #1;
    chk("t6 access gnt", {14'd0, gnt_a, gnt_b}, 16'h0000);
    @(negedge clk);
    req_b = 1'b1; addr_b = 16'h0004;
    #1;
    chk("t6 resp gnt_b", {15'd0, gnt_b}, 16'h0000);
    chk("t6 done_a", {15'd0, done_a}, 16'h0001);
    chk("t6 rdata_a", rdata_a, 16'h1234);
    @(negedge clk);
    #1;
    chk("t6 T+3 gnt_b", {15'd0, gnt_b}, 16'h0001);
    chk("t6 T+3 gnt_a", {15'd0, gnt_a}, 16'h0000);
    @(negedge clk);
    req_b = 1'b0;
    @(negedge clk);
    #1;
    chk("t6 done_b", {15'd0, done_b}, 16'h0001);
    chk("t6 rdata_b", rdata_b, 16'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
